// File: rtl/bp_resolve_queue_pkg.sv
// Shared branch-predictor types: queued prediction entry, predictor update payload.
package bp_resolve_queue_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t DELAY_SLOT_OFFSET = 32'd8;

  typedef struct packed {
    addr_t pc;
    logic  hit;
    logic  dpre;
    addr_t target;
  } bp_entry_t;

  typedef struct packed {
    logic  is_write;
    addr_t pc;
    addr_t dest;
    logic  taken;
  } bp_update_t;

  // A prediction only counts as taken when the predictor actually hit.
  function automatic logic pred_taken(input bp_entry_t e);
    return e.hit & e.dpre;
  endfunction

endpackage

// File: rtl/bp_resolve_queue_if.sv
// Fetch/execute/predictor-update bundle for the branch resolve queue.
interface bp_resolve_queue_if
  import bp_resolve_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             push_valid;
  addr_t            push_pc;
  logic             push_hit;
  logic             push_dpre;
  addr_t            push_target;
  logic             push_ready;
  logic             resolve_valid;
  addr_t            resolve_pc;
  logic             resolve_taken;
  addr_t            resolve_target;
  logic             mispredict;
  addr_t            redirect_pc;
  logic             upd_is_write;
  addr_t            upd_pc;
  addr_t            upd_dest_pc;
  logic             upd_taken;
  logic [CNT_W-1:0] count;

  modport master (
    output push_valid, push_pc, push_hit, push_dpre, push_target,
    output resolve_valid, resolve_pc, resolve_taken, resolve_target,
    input  push_ready, mispredict, redirect_pc,
    input  upd_is_write, upd_pc, upd_dest_pc, upd_taken, count
  );

  modport slave (
    input  push_valid, push_pc, push_hit, push_dpre, push_target,
    input  resolve_valid, resolve_pc, resolve_taken, resolve_target,
    output push_ready, mispredict, redirect_pc,
    output upd_is_write, upd_pc, upd_dest_pc, upd_taken, count
  );
endinterface

// File: rtl/bp_fifo.sv
// In-order prediction storage: circular buffer with occupancy count and synchronous clear.
module bp_fifo
  import bp_resolve_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  bp_entry_t                push_data,
  input  logic                     pop,
  input  logic                     clear,
  output bp_entry_t                head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PTR_BITS = $clog2(DEPTH);
  localparam int unsigned CNT_W    = PTR_BITS + 1;

  bp_entry_t           mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic                do_push_c;
  logic                do_pop_c;

  assign do_push_c = push && (count != CNT_W'(DEPTH));
  assign do_pop_c  = pop && (count != '0);
  assign head      = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + PTR_BITS'(1);
      count <= count + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bp_resolve_queue.sv
// Tracks fetch-time predictions in order, checks them at resolve, raises redirect and predictor update.
module bp_resolve_queue
  import bp_resolve_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  bp_resolve_queue_if.slave    bus
);
  localparam int unsigned PTR_BITS = $clog2(DEPTH);
  localparam int unsigned CNT_W    = PTR_BITS + 1;

  bp_entry_t        head;
  bp_entry_t        push_entry;
  logic [CNT_W-1:0] count;
  logic             empty_c;
  logic             mismatch_c;
  logic             push_c;
  logic             pop_c;
  addr_t            redirect_c;
  logic             mispredict_q;
  addr_t            redirect_q;
  bp_update_t       upd_q;

  assign empty_c         = (count == '0);
  assign bus.push_ready  = (count != CNT_W'(DEPTH));
  assign push_entry      = '{pc: bus.push_pc, hit: bus.push_hit,
                             dpre: bus.push_dpre, target: bus.push_target};

  // Resolve against the oldest prediction; an empty queue is a desync.
  always_comb begin
    mismatch_c = 1'b0;
    redirect_c = '0;
    pop_c      = 1'b0;
    push_c     = 1'b0;
    if (bus.resolve_valid) begin
      mismatch_c = empty_c
                || (head.pc != bus.resolve_pc)
                || (pred_taken(head) != bus.resolve_taken)
                || (bus.resolve_taken && (head.target != bus.resolve_target));
      pop_c      = !empty_c;
    end
    if (mismatch_c) begin
      redirect_c = bus.resolve_taken ? bus.resolve_target
                                     : bus.resolve_pc + DELAY_SLOT_OFFSET;
    end
    // Younger entries are wrong-path after a mismatch, so the flush also eats a same-cycle push.
    push_c = bus.push_valid && bus.push_ready && !mismatch_c;
  end

  bp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push_c),
    .push_data (push_entry),
    .pop       (pop_c),
    .clear     (mismatch_c),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      upd_q        <= '0;
    end else begin
      mispredict_q <= mismatch_c;
      redirect_q   <= redirect_c;
      if (bus.resolve_valid) begin
        upd_q <= '{is_write: 1'b1, pc: bus.resolve_pc,
                   dest: bus.resolve_target, taken: bus.resolve_taken};
      end else begin
        upd_q <= '0;
      end
    end
  end

  assign bus.mispredict   = mispredict_q;
  assign bus.redirect_pc  = redirect_q;
  assign bus.upd_is_write = upd_q.is_write;
  assign bus.upd_pc       = upd_q.pc;
  assign bus.upd_dest_pc  = upd_q.dest;
  assign bus.upd_taken    = upd_q.taken;
  assign bus.count        = CNT_W'(count);

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Self-checking bench: directed table, full/wrap and reset sequences, then random traffic vs. a queue model.
module tb_bp_resolve_queue;
  import bp_resolve_queue_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  bp_resolve_queue_if #(.DEPTH(DEPTH)) bus ();

  bp_resolve_queue #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bp_entry_t mq[$];

  typedef struct {
    logic  pv;  addr_t pc;  logic hit; logic dpre; addr_t tgt;
    logic  rv;  addr_t rpc; logic rt;  addr_t rtgt;
    logic  e_mis; addr_t e_redir; logic e_upd; int e_cnt;
  } vec_t;

  vec_t vt[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    bus.push_valid = 1'b0; bus.push_pc = '0; bus.push_hit = 1'b0;
    bus.push_dpre = 1'b0; bus.push_target = '0;
    bus.resolve_valid = 1'b0; bus.resolve_pc = '0;
    bus.resolve_taken = 1'b0; bus.resolve_target = '0;
  endtask

  // One clock: drive, advance the reference queue, then compare every output.
  task automatic step(input logic pv, input addr_t pc, input logic hit, input logic dpre,
                      input addr_t tgt, input logic rv, input addr_t rpc, input logic rt,
                      input addr_t rtgt);
    logic       ready;
    logic       mis;
    bp_entry_t  h;
    addr_t      e_redir;
    @(negedge clk);
    ready = (mq.size() != DEPTH);
    check("push_ready", 32'(bus.push_ready), 32'(ready));
    bus.push_valid = pv; bus.push_pc = pc; bus.push_hit = hit;
    bus.push_dpre = dpre; bus.push_target = tgt;
    bus.resolve_valid = rv; bus.resolve_pc = rpc;
    bus.resolve_taken = rt; bus.resolve_target = rtgt;
    mis = 1'b0;
    if (rv) begin
      if (mq.size() == 0) begin
        mis = 1'b1;
      end else begin
        h = mq[0];
        mis = (h.pc != rpc) || ((h.hit && h.dpre) != rt) || (rt && (h.target != rtgt));
        if (!mis) void'(mq.pop_front());
      end
    end
    if (mis) mq.delete();
    else if (pv && ready) mq.push_back('{pc: pc, hit: hit, dpre: dpre, target: tgt});
    e_redir = mis ? (rt ? rtgt : rpc + 32'd8) : 32'd0;
    @(posedge clk);
    #1;
    check("mispredict",   32'(bus.mispredict),   32'(mis));
    check("redirect_pc",  bus.redirect_pc,       e_redir);
    check("upd_is_write", 32'(bus.upd_is_write), 32'(rv));
    check("upd_pc",       bus.upd_pc,            rv ? rpc : 32'd0);
    check("upd_dest_pc",  bus.upd_dest_pc,       rv ? rtgt : 32'd0);
    check("upd_taken",    32'(bus.upd_taken),    32'(rv & rt));
    check("count",        32'(bus.count),        32'(mq.size()));
  endtask

  task automatic push_only(input addr_t pc, input logic hit, input logic dpre, input addr_t tgt);
    step(1'b1, pc, hit, dpre, tgt, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic resolve_nt(input addr_t rpc);
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, rpc, 1'b0, 32'd0);
  endtask

  initial begin
    addr_t r_pc, r_tgt, q_pc, q_tgt;
    logic  r_pv, r_hit, r_dpre, r_rv, r_rt;

    drive_idle();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_count",      32'(bus.count),      32'd0);
    check("rst_push_ready", 32'(bus.push_ready), 32'd1);
    check("rst_mispredict", 32'(bus.mispredict), 32'd0);
    check("rst_upd",        32'(bus.upd_is_write), 32'd0);
    resetn = 1'b1;

    // Directed vectors: hit/taken match, miss-but-taken, taken-vs-not-taken, empty desync, flush eats push.
    vt[0] = '{1'b1, 32'h8000_0010, 1'b1, 1'b1, 32'h8000_0100, 1'b0, 32'h0, 1'b0, 32'h0,
              1'b0, 32'h0, 1'b0, 1};
    vt[1] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0100,
              1'b0, 32'h0, 1'b1, 0};
    vt[2] = '{1'b1, 32'h8000_0020, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
              1'b0, 32'h0, 1'b0, 1};
    vt[3] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0020, 1'b1, 32'h8000_0400,
              1'b1, 32'h8000_0400, 1'b1, 0};
    vt[4] = '{1'b1, 32'h8000_0030, 1'b1, 1'b1, 32'h8000_0300, 1'b0, 32'h0, 1'b0, 32'h0,
              1'b0, 32'h0, 1'b0, 1};
    vt[5] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0030, 1'b0, 32'h0,
              1'b1, 32'h8000_0038, 1'b1, 0};
    vt[6] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0040, 1'b0, 32'h0,
              1'b1, 32'h8000_0048, 1'b1, 0};
    vt[7] = '{1'b1, 32'h8000_0050, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
              1'b0, 32'h0, 1'b0, 1};
    vt[8] = '{1'b1, 32'h8000_0060, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0999, 1'b0, 32'h0,
              1'b1, 32'h8000_09a1, 1'b1, 0};
    for (int i = 0; i < 9; i++) begin
      step(vt[i].pv, vt[i].pc, vt[i].hit, vt[i].dpre, vt[i].tgt,
           vt[i].rv, vt[i].rpc, vt[i].rt, vt[i].rtgt);
      check($sformatf("tbl%0d_mis", i),   32'(bus.mispredict),   32'(vt[i].e_mis));
      check($sformatf("tbl%0d_redir", i), bus.redirect_pc,       vt[i].e_redir);
      check($sformatf("tbl%0d_upd", i),   32'(bus.upd_is_write), 32'(vt[i].e_upd));
      check($sformatf("tbl%0d_cnt", i),   32'(bus.count),        32'(vt[i].e_cnt));
    end

    // Fill, overflow, pop under full, pop+push with wrap, then drain in order.
    for (int i = 0; i < 8; i++) push_only(32'h100 + 32'(4 * i), 1'b0, 1'b0, 32'h0);
    check("full_count", 32'(bus.count), 32'd8);
    check("full_ready", 32'(bus.push_ready), 32'd0);
    push_only(32'h200, 1'b0, 1'b0, 32'h0);
    check("drop_count", 32'(bus.count), 32'd8);
    step(1'b1, 32'h204, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0);
    check("pop_full_count", 32'(bus.count), 32'd7);
    step(1'b1, 32'h120, 1'b0, 1'b0, 32'h0, 1'b1, 32'h104, 1'b0, 32'h0);
    check("pushpop_count", 32'(bus.count), 32'd7);
    push_only(32'h124, 1'b0, 1'b0, 32'h0);
    check("refill_count", 32'(bus.count), 32'd8);
    for (int i = 2; i < 8; i++) resolve_nt(32'h100 + 32'(4 * i));
    resolve_nt(32'h120);
    check("wrap_mis", 32'(bus.mispredict), 32'd0);
    resolve_nt(32'h124);
    check("wrap_last_mis", 32'(bus.mispredict), 32'd0);
    check("drain_count", 32'(bus.count), 32'd0);

    // Reset mid-stream with five entries queued and an update pulse pending.
    for (int i = 0; i < 6; i++) push_only(32'h300 + 32'(4 * i), 1'b1, 1'b1, 32'h900 + 32'(i));
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b1, 32'h900);
    check("pre_rst_count", 32'(bus.count), 32'd5);
    check("pre_rst_upd",   32'(bus.upd_is_write), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("midrst_count", 32'(bus.count), 32'd0);
    check("midrst_ready", 32'(bus.push_ready), 32'd1);
    check("midrst_upd",   32'(bus.upd_is_write), 32'd0);
    check("midrst_updpc", bus.upd_pc, 32'd0);
    check("midrst_mis",   32'(bus.mispredict), 32'd0);
    mq.delete();
    drive_idle();
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Random traffic, mostly well-behaved resolves with occasional injected mismatches.
    for (int n = 0; n < 3000; n++) begin
      r_pv   = ($urandom_range(0, 99) < 55);
      r_pc   = $urandom() & 32'hffff_fffc;
      r_hit  = 1'($urandom_range(0, 1));
      r_dpre = 1'($urandom_range(0, 1));
      r_tgt  = $urandom() & 32'hffff_fffc;
      r_rv   = ($urandom_range(0, 99) < 45);
      q_pc   = $urandom() & 32'hffff_fffc;
      q_tgt  = $urandom() & 32'hffff_fffc;
      r_rt   = 1'($urandom_range(0, 1));
      if (mq.size() != 0 && $urandom_range(0, 99) < 88) begin
        q_pc = mq[0].pc;
        r_rt = mq[0].hit & mq[0].dpre;
        if (r_rt) q_tgt = mq[0].target;
      end
      step(r_pv, r_pc, r_hit, r_dpre, r_tgt, r_rv, q_pc, r_rt, q_tgt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
